// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/control FSM driving the dual-read register file and ALU.
module instr_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int START_ADDR  = 0,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_data,
  output logic [15:0]         opcode,
  output logic [3:0]          addr_1,
  output logic [3:0]          addr_2,
  output logic [3:0]          addr_3,
  output logic                write_enable,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic                ram_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                error
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, WAIT_RAM, READ_HOLD, WRITEBACK, HALTED, ERROR
  } state_t;
  state_t state, state_n;
  logic [27:0] instr, instr_n;
  logic [PC_WIDTH-1:0] pc_n, pc_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] op;
  logic unused_nibble;
  assign unused_nibble = ^imem_data[3:0];
  assign op = instr[27:12];
  assign pc_inc = pc + PC_WIDTH'(1);
  assign imem_addr = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    cnt_n = cnt;
    case (state)
      IDLE, HALTED, ERROR: begin
        state_n = start ? FETCH : state;
        pc_n = start ? PC_WIDTH'(START_ADDR) : pc;
      end
      FETCH: begin
        state_n = imem_valid ? DECODE : FETCH;
        instr_n = imem_valid ? imem_data[31:4] : instr;
      end
      DECODE: begin
        state_n = op == 16'hFFFF ? HALTED :
                  op[15:12] == 4'h1 ? EXEC :
                  op[15:8] == 8'h42 ? WAIT_RAM :
                  op[15:8] == 8'h22 ? READ_HOLD : FETCH;
        cnt_n = '0;
      end
      EXEC: begin
        state_n = alu_done ? WRITEBACK : cnt == CW'(ALU_TIMEOUT - 1) ? ERROR : EXEC;
        cnt_n = cnt + CW'(1);
      end
      WAIT_RAM: state_n = ram_valid ? WRITEBACK : WAIT_RAM;
      READ_HOLD, WRITEBACK: state_n = FETCH;
      default: state_n = IDLE;
    endcase
    // the advance step is folded into every return to FETCH from a finished instruction
    if (state_n == FETCH && state inside {DECODE, READ_HOLD, WRITEBACK})
      pc_n = pc_inc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      cnt <= '0;
      imem_req <= 1'b0;
      alu_start <= 1'b0;
      write_enable <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
      error <= 1'b0;
      {opcode, addr_1, addr_2, addr_3} <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      cnt <= cnt_n;
      imem_req <= state_n == FETCH;
      alu_start <= state_n == EXEC && state != EXEC;
      write_enable <= state_n == WRITEBACK;
      busy <= !(state_n inside {IDLE, HALTED, ERROR});
      halted <= state_n == HALTED;
      error <= state_n == ERROR;
      {opcode, addr_1, addr_2, addr_3} <=
        state_n inside {DECODE, EXEC, WAIT_RAM, READ_HOLD, WRITEBACK} ? instr_n : '0;
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table vectors, directed corner sequences and random programs vs a program-level model.
module tb_instr_sequencer;
  logic clk = 0, reset = 1, start = 0, imem_valid = 0, alu_done = 0, ram_valid = 0;
  logic [31:0] imem_data = 0;
  logic imem_req, write_enable, alu_start, busy, halted, error;
  logic [7:0] imem_addr, pc;
  logic [15:0] opcode;
  logic [3:0] addr_1, addr_2, addr_3;
  logic start2 = 0, imem_valid2 = 0, alu_done2 = 0, ram_valid2 = 0;
  logic [31:0] imem_data2 = 0;
  logic imem_req2, write_enable2, alu_start2, busy2, halted2, error2;
  logic [1:0] imem_addr2, pc2;
  logic [15:0] opcode2;
  logic [3:0] a1_2, a2_2, a3_2;

  instr_sequencer #(.PC_WIDTH(8), .START_ADDR(0), .ALU_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .opcode(opcode), .addr_1(addr_1),
    .addr_2(addr_2), .addr_3(addr_3), .write_enable(write_enable), .alu_start(alu_start),
    .alu_done(alu_done), .ram_valid(ram_valid), .pc(pc), .busy(busy), .halted(halted), .error(error));

  instr_sequencer #(.PC_WIDTH(2), .START_ADDR(0), .ALU_TIMEOUT(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_data(imem_data2), .opcode(opcode2), .addr_1(a1_2),
    .addr_2(a2_2), .addr_3(a3_2), .write_enable(write_enable2), .alu_start(alu_start2),
    .alu_done(alu_done2), .ram_valid(ram_valid2), .pc(pc2), .busy(busy2), .halted(halted2), .error(error2));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; int we; int alu; int pc; } vec_t;
  vec_t tbl[12];
  logic [31:0] mem [256];
  int checks = 0, failures = 0, cyc = 0;
  int fdelay = 0, adelay = 0, rdelay = 0, fcnt = 0, acnt = 0, rcnt = 0;
  bit stray = 0, apend = 0, err_seen = 0, cap_next = 0;
  int n_alu, n_we, n_2200, req_cycles, stab_err, bad2 = 0;
  int cyc_alu, cyc_we, cyc_err;
  logic prev_req, prev_valid;
  logic [7:0] prev_addr;
  logic [3:0] we_a1, we_a2;
  int got_fetch[$], fetch2[$], exp_fetch[$];
  logic [15:0] dec_q[$];
  logic [19:0] got_wb[$], exp_wb[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_alu = 0; n_we = 0; n_2200 = 0; req_cycles = 0; stab_err = 0;
    cyc_alu = 0; cyc_we = 0; cyc_err = 0; err_seen = 0; cap_next = 0; apend = 0;
    prev_req = 0; prev_valid = 0; prev_addr = 0; fcnt = 0; rcnt = 0;
    got_fetch.delete(); dec_q.delete(); got_wb.delete();
  endtask

  task automatic load_halt();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_0000;
  endtask

  // one cycle: respond to DUT requests at the falling edge and record observed events
  task automatic tick();
    bit rq;
    @(negedge clk);
    cyc++;
    if (!imem_req) fcnt = 0;
    imem_data = mem[imem_addr];
    imem_valid = imem_req ? (fcnt == fdelay) : (stray && $urandom_range(0, 3) == 0);
    if (imem_req) begin req_cycles++; fcnt++; end
    if (alu_start) begin apend = 1; acnt = 0; n_alu++; cyc_alu = cyc; end
    alu_done = (apend && acnt == adelay) || (stray && imem_req && $urandom_range(0, 2) == 0);
    if (apend && acnt == adelay) apend = 0;
    else if (apend) acnt++;
    rq = busy && opcode[15:8] == 8'h42 && !write_enable;
    rcnt = rq ? rcnt + 1 : 0;
    ram_valid = (rq && rcnt > rdelay) || (stray && imem_req && $urandom_range(0, 2) == 0);
    start = stray && busy && $urandom_range(0, 3) == 0;
    if (cap_next) begin dec_q.push_back(opcode); cap_next = 0; end
    if (imem_req && imem_valid) begin got_fetch.push_back(int'(imem_addr)); cap_next = 1; end
    if (write_enable) begin
      n_we++; cyc_we = cyc; got_wb.push_back({opcode, addr_3}); we_a1 = addr_1; we_a2 = addr_2;
    end
    if (opcode == 16'h2200) n_2200++;
    if (error && !err_seen) begin err_seen = 1; cyc_err = cyc; end
    if (prev_req && !prev_valid && (!imem_req || imem_addr != prev_addr)) stab_err++;
    prev_req = imem_req; prev_valid = imem_valid; prev_addr = imem_addr;
    start2 = 0; imem_valid2 = imem_req2; imem_data2 = 32'h0; alu_done2 = 0; ram_valid2 = 0;
    if (imem_req2) fetch2.push_back(int'(imem_addr2));
    if (write_enable2 || alu_start2 || halted2) bad2++;
  endtask

  task automatic run_to_stop(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = halted || error;
    end
    chk({name, "_stops"}, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int mpc, ea;
    logic [31:0] w;
    bit seen;
    tbl[0]  = '{32'h1123_4560, 1, 1, 1};
    tbl[1]  = '{32'h1FFF_0000, 1, 1, 1};
    tbl[2]  = '{32'hFFFF_1230, 0, 0, 0};
    tbl[3]  = '{32'hFFFE_0000, 0, 0, 1};
    tbl[4]  = '{32'h4200_0030, 1, 0, 1};
    tbl[5]  = '{32'h42FF_00F0, 1, 0, 1};
    tbl[6]  = '{32'h4300_0000, 0, 0, 1};
    tbl[7]  = '{32'h2200_0000, 0, 0, 1};
    tbl[8]  = '{32'h2201_0070, 0, 0, 1};
    tbl[9]  = '{32'h0000_0000, 0, 0, 1};
    tbl[10] = '{32'h0142_0000, 0, 0, 1};
    tbl[11] = '{32'h1422_0090, 1, 1, 1};
    load_halt();
    clear_mon();
    reset = 1;
    tick();
    chk("reset_outputs", {imem_req, imem_addr, opcode, addr_1, addr_2, addr_3,
        write_enable, alu_start, pc, busy, halted, error}, 0);
    tick();
    reset = 0;
    tick();
    chk("idle_not_busy", {busy, imem_req}, 0);

    // ALU instruction, 1-cycle fetch, done three cycles after launch
    mem[0] = 32'h1123_4560;
    clear_mon(); adelay = 3;
    start = 1;
    run_to_stop("alu", 200);
    chk("alu_dec_op", dec_q[0], 16'h1123);
    chk("alu_we_op_a3", got_wb[0], {16'h1123, 4'h6});
    chk("alu_we_a1_a2", {we_a1, we_a2}, {4'h4, 4'h5});
    chk("alu_start_pulses", n_alu, 1);
    chk("alu_we_cycles", n_we, 1);
    chk("alu_we_after_start", cyc_we - cyc_alu, 4);
    chk("alu_next_fetch_addr", got_fetch[1], 1);
    chk("alu_halt_pc", {halted, pc}, {1'b1, 8'd1});

    // narrow PC wraps through all four addresses with NOPs
    start2 = 1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin tick(); seen = fetch2.size() >= 5; end
    chk("pc2_fetch_count", seen, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("pc2_fetch%0d", i), fetch2[i], i % 4);

    // RAM write then READ then HALT
    load_halt();
    mem[0] = 32'h4200_0030; mem[1] = 32'h2200_0030; mem[2] = 32'hFFFF_0000;
    clear_mon(); rdelay = 2;
    start = 1;
    run_to_stop("mem", 200);
    chk("mem_we_count", n_we, 1);
    chk("mem_we_op_a3", got_wb[0], {16'h4200, 4'h3});
    chk("mem_read_hold", n_2200, 2);
    chk("mem_alu_none", n_alu, 0);
    chk("mem_halt_state", {halted, busy, pc}, {1'b1, 1'b0, 8'd2});
    start = 1;
    tick();
    chk("mem_restart", {halted, busy, pc}, {1'b0, 1'b1, 8'd0});
    run_to_stop("mem_rerun", 200);

    for (int t = 0; t < 12; t++) begin
      load_halt(); mem[0] = tbl[t].instr;
      clear_mon(); adelay = 1; rdelay = 1;
      start = 1;
      run_to_stop($sformatf("tbl%0d", t), 300);
      chk($sformatf("tbl%0d_we", t), n_we, tbl[t].we);
      chk($sformatf("tbl%0d_alu", t), n_alu, tbl[t].alu);
      chk($sformatf("tbl%0d_pc_halt", t), {halted, pc}, {1'b1, 8'(tbl[t].pc)});
      chk($sformatf("tbl%0d_dec", t), dec_q[0], tbl[t].instr[31:16]);
    end

    // ALU that never completes
    load_halt();
    mem[0] = 32'h0000_0000; mem[1] = 32'h1000_0010;
    clear_mon(); adelay = 1000;
    start = 1;
    run_to_stop("tmo", 300);
    chk("tmo_error", {error, halted, busy}, 3'b100);
    chk("tmo_latency", cyc_err - cyc_alu, 64);
    chk("tmo_no_we", n_we, 0);
    chk("tmo_pc_frozen", pc, 1);
    chk("tmo_opcode_zero", opcode, 0);
    start = 1;
    tick();
    chk("tmo_restart", {error, imem_req, pc}, {1'b0, 1'b1, 8'd0});
    run_to_stop("tmo_rerun", 300);

    // slow fetch with stray start/alu_done/ram_valid/imem_valid
    load_halt();
    mem[0] = 32'h1ABC_DEF0; mem[1] = 32'h0000_0000;
    clear_mon(); fdelay = 5; adelay = 2; stray = 1;
    start = 1;
    run_to_stop("slow", 400);
    stray = 0; fdelay = 0;
    chk("slow_req_stable", stab_err, 0);
    chk("slow_req_cycles", req_cycles, 18);
    chk("slow_fetch_count", got_fetch.size(), 3);
    chk("slow_fetch_last", got_fetch[2], 2);
    chk("slow_we", {n_we, got_wb[0]}, {32'd1, 16'h1ABC, 4'hF});
    chk("slow_halt_pc", {halted, pc}, {1'b1, 8'd2});

    for (int p = 0; p < 15; p++) begin
      load_halt();
      for (int i = 0; i < 16; i++) begin
        int s;
        logic [31:0] r;
        s = $urandom_range(0, 9);
        r = $urandom;
        mem[i] = s < 3 ? {4'h1, r[27:0]} : s < 5 ? {8'h42, r[23:0]} :
                 s < 7 ? {8'h22, r[23:0]} : s < 9 ? r : {16'hFFFF, r[15:0]};
      end
      fdelay = $urandom_range(0, 4); adelay = $urandom_range(0, 10); rdelay = $urandom_range(0, 4);
      exp_fetch.delete(); exp_wb.delete(); ea = 0; mpc = 0;
      while (1) begin
        exp_fetch.push_back(mpc);
        w = mem[mpc];
        if (w[31:16] == 16'hFFFF) break;
        if (w[31:28] == 4'h1) begin ea++; exp_wb.push_back({w[31:16], w[7:4]}); end
        else if (w[31:24] == 8'h42) exp_wb.push_back({w[31:16], w[7:4]});
        mpc = (mpc + 1) % 256;
      end
      clear_mon(); stray = 1;
      start = 1;
      run_to_stop($sformatf("rnd%0d", p), 3000);
      stray = 0;
      chk($sformatf("rnd%0d_halt_pc", p), {halted, pc}, {1'b1, 8'(mpc)});
      chk($sformatf("rnd%0d_alu", p), n_alu, ea);
      chk($sformatf("rnd%0d_nfetch", p), got_fetch.size(), exp_fetch.size());
      chk($sformatf("rnd%0d_nwb", p), got_wb.size(), exp_wb.size());
      for (int i = 0; i < exp_fetch.size(); i++) chk($sformatf("rnd%0d_fetch%0d", p, i), got_fetch[i], exp_fetch[i]);
      for (int i = 0; i < exp_wb.size(); i++) chk($sformatf("rnd%0d_wb%0d", p, i), got_wb[i], exp_wb[i]);
    end
    fdelay = 0;

    // asynchronous reset while waiting in EXEC
    load_halt();
    mem[0] = 32'h1555_5550;
    clear_mon(); adelay = 1000;
    start = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin tick(); seen = n_alu == 1; end
    tick(); tick(); tick();
    chk("rst_in_exec", {busy, opcode}, {1'b1, 16'h1555});
    #2 reset = 1;
    #1;
    chk("rst_async_outputs", {imem_req, imem_addr, opcode, addr_1, addr_2, addr_3,
        write_enable, alu_start, pc, busy, halted, error}, 0);
    tick();
    reset = 0;
    clear_mon();
    repeat (80) tick();
    chk("rst_idle_quiet", {n_we, req_cycles}, 0);
    chk("rst_idle_flags", {busy, halted, error}, 0);
    adelay = 0;
    start = 1;
    run_to_stop("rst_rerun", 200);
    chk("rst_rerun_we", {n_we, halted}, {32'd1, 1'b1});
    chk("dut2_never_we_alu_halt", bad2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
